store_buffer: RTL and testbench

Word-wide store buffer placed directly upstream of the MIPS data memory (byte-addressed, big-endian, 32 × 4-byte array, write on posedge, combinational read). It accepts store requests from the datapath, holds them in a small FIFO and drains them to the memory write port in cycles with no load. Loads are served combinationally, either from memory or from the youngest matching buffered store, so the buffer is transparent to software.

---
 rtl/store_buffer.sv | 146 ++++++++++++++
 tb/tb_store_buffer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Brief    : Word-wide store FIFO ahead of data memory, drains in load-free
//            cycles and forwards youngest matching store to loads.
//            Optional STORE_BUFFER_COALESCE_EN merges same-word pushes.
// Revision : 1.0
// ============================================================================
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic [DATA_W-1:0]        ld_data,
  output logic                     ld_hit,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_data,
  input  logic [DATA_W-1:0]        mem_q,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_1 = PTR_W'(1);

  logic [WA_W-1:0]   addr_q [DEPTH];
  logic [WA_W-1:0]   addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push;
  logic              pop;
  logic              coalesce;
  logic              alloc;
  logic [WA_W-1:0]   st_wa;
  logic [WA_W-1:0]   ld_wa;
  logic [PTR_W-1:0]  fwd_idx;
  logic              unused_lsbs;

  assign st_wa       = st_addr[ADDR_W-1:2];
  assign ld_wa       = ld_addr[ADDR_W-1:2];
  assign unused_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  // Ready looks only at the registered count; a same-cycle pop never helps.
  assign st_ready = (count_q < C_DEPTH);
  assign push     = st_valid && st_ready;
  assign pop      = (count_q != '0) && !ld_en;
  assign alloc    = push && !coalesce;
  assign count    = count_q;
  assign empty    = (count_q == '0);

`ifdef STORE_BUFFER_COALESCE_EN
  logic [PTR_W-1:0] youngest;
  assign youngest = tail_q - C_PTR_1;
  // With a single entry being popped this cycle, merging would lose the data.
  assign coalesce = push && (count_q != '0) && (addr_q[youngest] == st_wa) &&
                    !(pop && (count_q == C_ONE));
`else
  assign coalesce = 1'b0;
`endif

  // Memory port: loads own the address bus, otherwise the head drains.
  always_comb begin
    mem_we   = pop;
    mem_addr = '0;
    mem_data = '0;
    if (ld_en) begin
      mem_addr = {ld_wa, 2'b00};
    end else if (pop) begin
      mem_addr = {addr_q[head_q], 2'b00};
      mem_data = data_q[head_q];
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = mem_q;
    fwd_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head_q + PTR_W'(k);
      if ((CNT_W'(k) < count_q) && (addr_q[fwd_idx] == ld_wa)) begin
        ld_hit  = 1'b1;
        ld_data = data_q[fwd_idx];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
    end
    head_d  = head_q;
    tail_d  = tail_q;
    if (coalesce) begin
      data_d[tail_q - C_PTR_1] = st_data;
    end else if (push) begin
      addr_d[tail_q] = st_wa;
      data_d[tail_q] = st_data;
      tail_d         = tail_q + C_PTR_1;
    end
    if (pop) begin
      head_d = head_q + C_PTR_1;
    end
    count_d = count_q + CNT_W'(alloc) - CNT_W'(pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Brief    : Directed self-checking bench for store_buffer with a behavioural
//            32-word data memory and a log of every memory write.
// Revision : 1.0
// ============================================================================
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic        st_ready;
  logic [6:0]  st_addr;
  logic [31:0] st_data;
  logic        ld_en;
  logic [6:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_hit;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_data;
  logic [31:0] mem_q;
  logic [2:0]  count;
  logic        empty;

  int checks   = 0;
  int failures = 0;
  int base;

  logic [31:0] mem [32] = '{16: 32'hDEADBEEF, default: 32'h0};
  logic [6:0]  wr_addr_log [$];
  logic [31:0] wr_data_log [$];

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4), .ADDR_W(7), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_hit(ld_hit),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data), .mem_q(mem_q),
    .count(count), .empty(empty)
  );

  assign mem_q = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr[6:2]] <= mem_data;
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [6:0] a, input logic [31:0] d);
    if (idx < wr_addr_log.size()) begin
      chk({tag, "_addr"}, {25'h0, wr_addr_log[idx]}, {25'h0, a});
      chk({tag, "_data"}, wr_data_log[idx], d);
    end else begin
      chk({tag, "_missing"}, 32'(wr_addr_log.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; st_valid = 1'b0; st_addr = '0; st_data = '0; ld_en = 1'b0; ld_addr = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_ready", 32'(st_ready), 32'd1);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_hit", 32'(ld_hit), 32'd0);
    chk("idle_addr", 32'(mem_addr), 32'd0);
    chk("idle_data", mem_data, 32'd0);

    // Streaming: three consecutive pushes, each drained the following cycle.
    st_valid = 1'b1; st_addr = 7'h04; st_data = 32'h11111111; #1;
    chk("str_we0", 32'(mem_we), 32'd0);
    tick();
    st_addr = 7'h08; st_data = 32'h22222222; #1;
    chk("str_we1", 32'(mem_we), 32'd1);
    chk("str_addr1", 32'(mem_addr), 32'h04);
    chk("str_data1", mem_data, 32'h11111111);
    chk("str_cnt1", 32'(count), 32'd1);
    tick();
    st_addr = 7'h0C; st_data = 32'h33333333; #1;
    chk("str_addr2", 32'(mem_addr), 32'h08);
    chk("str_data2", mem_data, 32'h22222222);
    chk("str_cnt2", 32'(count), 32'd1);
    tick();
    st_valid = 1'b0; #1;
    chk("str_addr3", 32'(mem_addr), 32'h0C);
    chk("str_data3", mem_data, 32'h33333333);
    tick();
    chk("str_empty", 32'(empty), 32'd1);
    chk("str_we_off", 32'(mem_we), 32'd0);
    chk_log("str_log0", 0, 7'h04, 32'h11111111);
    chk_log("str_log1", 1, 7'h08, 32'h22222222);
    chk_log("str_log2", 2, 7'h0C, 32'h33333333);
    ld_en = 1'b1; ld_addr = 7'h08; #1;
    chk("str_rd", ld_data, 32'h22222222);
    chk("str_rd_hit", 32'(ld_hit), 32'd0);

    // Fill / block: loads hold off draining, fifth push is refused.
    ld_addr = 7'h40;
    for (int i = 0; i < 5; i++) begin
      st_valid = 1'b1; st_addr = 7'(8'h20 + 8'(4 * i)); st_data = 32'h50000000 + 32'(i); #1;
      chk("fill_ready", 32'(st_ready), (i < 4) ? 32'd1 : 32'd0);
      tick();
    end
    st_valid = 1'b0; #1;
    chk("fill_cnt", 32'(count), 32'd4);
    chk("fill_ready_lo", 32'(st_ready), 32'd0);
    chk("fill_we", 32'(mem_we), 32'd0);
    chk("fill_maddr", 32'(mem_addr), 32'h40);
    chk("fill_ld", ld_data, 32'hDEADBEEF);
    chk("fill_hit", 32'(ld_hit), 32'd0);
    base = wr_addr_log.size();
    ld_en = 1'b0; ld_addr = '0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("fill_drain_we", 32'(mem_we), 32'd1);
      chk("fill_drain_addr", 32'(mem_addr), 32'h20 + 32'(4 * j));
      tick();
    end
    chk("fill_empty", 32'(empty), 32'd1);
    chk("fill_nwr", 32'(wr_addr_log.size()), 32'(base + 4));
    for (int j = 0; j < 4; j++) chk_log("fill_log", base + j, 7'(8'h20 + 8'(4 * j)), 32'h50000000 + 32'(j));
    chk("fill_dropped", mem[12], 32'h0);

    // Forwarding of the youngest matching store.
    ld_en = 1'b1; ld_addr = 7'h12;
    st_valid = 1'b1; st_addr = 7'h10; st_data = 32'hAAAA0001; #1;
    chk("fwd_nopush_hit", 32'(ld_hit), 32'd0);
    chk("fwd_nopush_data", ld_data, 32'h0);
    tick();
    st_data = 32'hAAAA0002; #1;
    chk("fwd_hit1", 32'(ld_hit), 32'd1);
    chk("fwd_data1", ld_data, 32'hAAAA0001);
    tick();
    st_valid = 1'b0; #1;
    chk("fwd_hit2", 32'(ld_hit), 32'd1);
    chk("fwd_data2", ld_data, 32'hAAAA0002);
`ifdef STORE_BUFFER_COALESCE_EN
    chk("fwd_cnt", 32'(count), 32'd1);
`else
    chk("fwd_cnt", 32'(count), 32'd2);
`endif
    ld_en = 1'b0;
    for (int n = 0; n < 8 && !empty; n++) tick();
    chk("fwd_drained", 32'(empty), 32'd1);
    chk("fwd_mem", mem[4], 32'hAAAA0002);

    // Alignment: low address bits are dropped on the memory side.
    st_valid = 1'b1; st_addr = 7'h13; st_data = 32'h0BADF00D;
    tick();
    st_valid = 1'b0; #1;
    chk("aln_we", 32'(mem_we), 32'd1);
    chk("aln_addr", 32'(mem_addr), 32'h10);
    chk("aln_data", mem_data, 32'h0BADF00D);
    tick();
    ld_en = 1'b1; ld_addr = 7'h11; #1;
    chk("aln_maddr", 32'(mem_addr), 32'h10);
    chk("aln_ld", ld_data, 32'h0BADF00D);
    chk("aln_hit", 32'(ld_hit), 32'd0);

    // Wrap: ten pushes with loads interleaved, pointers wrap several times.
    base = wr_addr_log.size();
    ld_addr = 7'h00;
    for (int i = 0; i < 10; i++) begin
      st_valid = 1'b1; st_addr = 7'(8'h44 + 8'(4 * i)); st_data = 32'hC0DE0000 + 32'(i);
      ld_en = (i % 3 == 0); #1;
      chk("wrap_ready", 32'(st_ready), 32'd1);
      tick();
    end
    st_valid = 1'b0; ld_en = 1'b0;
    for (int n = 0; n < 8 && !empty; n++) tick();
    chk("wrap_empty", 32'(empty), 32'd1);
    chk("wrap_nwr", 32'(wr_addr_log.size()), 32'(base + 10));
    for (int j = 0; j < 10; j++) chk_log("wrap_log", base + j, 7'(8'h44 + 8'(4 * j)), 32'hC0DE0000 + 32'(j));

    // Asynchronous reset in the middle of a drain discards the buffer.
    ld_en = 1'b1; ld_addr = 7'h00;
    for (int i = 0; i < 3; i++) begin
      st_valid = 1'b1; st_addr = 7'(8'h70 + 8'(4 * i)); st_data = 32'hF0000000 + 32'(i);
      tick();
    end
    st_valid = 1'b0; ld_en = 1'b0; #1;
    chk("rd_cnt3", 32'(count), 32'd3);
    chk("rd_we", 32'(mem_we), 32'd1);
    rst = 1'b1; #1;
    chk("rd_cnt0", 32'(count), 32'd0);
    chk("rd_empty", 32'(empty), 32'd1);
    chk("rd_we0", 32'(mem_we), 32'd0);
    chk("rd_ready", 32'(st_ready), 32'd1);
    base = wr_addr_log.size();
    tick(); tick();
    rst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rd_nowr", 32'(wr_addr_log.size()), 32'(base));
    chk("rd_mem", mem[28], 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
